// File: rtl/ras_pkg.sv
// Shared types for the return-address-stack resolve block: resolver state
// encoding and the default program-counter width.
package ras_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    REDIR = 2'd2
  } ras_state_e;

  localparam int RAS_PC_WIDTH = 32;

endpackage

// File: rtl/ras_pred_fifo.sv
// In-flight return-address prediction queue: FIFO of 2**QSIZE entries with
// a synchronous clear that wins over any same-cycle push or pop.
module ras_pred_fifo
  import ras_pkg::*;
#(
  parameter int PC_WIDTH = RAS_PC_WIDTH,
  parameter int QSIZE    = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                push_i,
  input  logic [PC_WIDTH-1:0] push_data_i,
  input  logic                pop_i,
  input  logic                clear_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [PC_WIDTH-1:0] head_o,
  output logic [QSIZE:0]      count_o
);

  localparam int DEPTH = 1 << QSIZE;

  logic [PC_WIDTH-1:0] mem_q [DEPTH];
  logic [QSIZE-1:0]    wptr_q, wptr_d;
  logic [QSIZE-1:0]    rptr_q, rptr_d;
  logic [QSIZE:0]      count_q, count_d;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == (QSIZE+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + QSIZE'(1);
      if (pop_ok)  rptr_d = rptr_q + QSIZE'(1);
      count_d = count_q + (QSIZE+1)'(push_ok) - (QSIZE+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is data only; stale entries are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ras_resolve.sv
// Checks return-stack predictions against resolved jr targets and issues a
// registered one-cycle redirect on mispredict. Optional hit/miss counters are
// enabled by defining RAS_RESOLVE_STATS_EN.
module ras_resolve
  import ras_pkg::*;
#(
  parameter int PC_WIDTH = RAS_PC_WIDTH,
  parameter int QSIZE    = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                pred_valid,
  input  logic [PC_WIDTH-1:0] pred_addr,
  output logic                pred_ready,
  input  logic                res_valid,
  input  logic [PC_WIDTH-1:0] res_target,
  input  logic                flush,
  output logic                redirect,
  output logic [PC_WIDTH-1:0] redirect_pc,
`ifdef RAS_RESOLVE_STATS_EN
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
`endif
  output logic                err_ovf
);

  ras_state_e          state_q, state_d;
  logic                redirect_q;
  logic [PC_WIDTH-1:0] redirect_pc_q;
  logic                err_ovf_q;

  logic                full, empty, in_redir;
  logic [PC_WIDTH-1:0] head;
  logic [QSIZE:0]      count;
  logic                push, res_act, hit, miss, clear;

  assign in_redir   = (state_q == REDIR);
  assign pred_ready = ~full & ~in_redir;
  assign push       = pred_valid & pred_ready;
  // Resolutions during the redirect cycle are wrong-path; flush squashes them.
  assign res_act    = res_valid & ~in_redir & ~flush;
  assign hit        = res_act & ~empty & (head == res_target);
  assign miss       = res_act & ~hit;
  assign clear      = flush | miss;

  ras_pred_fifo #(
    .PC_WIDTH (PC_WIDTH),
    .QSIZE    (QSIZE)
  ) u_fifo (
    .clk         (clk),
    .rst_b       (rst_b),
    .push_i      (push),
    .push_data_i (pred_addr),
    .pop_i       (hit),
    .clear_i     (clear),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head),
    .count_o     (count)
  );

  always_comb begin
    state_d = state_q;
    if (flush || in_redir) begin
      state_d = IDLE;
    end else if (miss) begin
      state_d = REDIR;
    end else if (push || (count > (QSIZE+1)'(hit))) begin
      state_d = TRACK;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      redirect_q <= miss;
      if (miss) redirect_pc_q <= res_target;
      err_ovf_q  <= err_ovf_q | (pred_valid & ~pred_ready);
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign err_ovf     = err_ovf_q;

`ifdef RAS_RESOLVE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
